aux_bus_bridge: RTL and testbench

- Sits directly downstream of the CPU's aux bus port.
- Accepts the CPU's fire-and-forget aux requests and honours the next-cycle abort from the MPU.
- Buffers surviving requests in a FIFO and serialises them onto a shared one-hot-select peripheral register bus.
- Returns read data to the CPU with the original 9-bit tag.

---
 rtl/aux_bus_bridge.sv | 219 +++++++++++++++++++++
 tb/tb_aux_bus_bridge.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aux_bus_bridge.sv
// CPU aux-bus to peripheral register-bus bridge: capture stage with next-cycle abort,
// request FIFO, and a single-outstanding serialiser onto a one-hot-select slave bus.
module aux_bus_bridge #(
    parameter int unsigned NUM_SLAVES = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] AUX_BASE   = 16'hE000,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_aux_request,
    input  logic [31:0]           cpu_aux_addr,
    input  logic                  cpu_aux_write,
    input  logic [3:0]            cpu_aux_wstrb,
    input  logic [31:0]           cpu_aux_wdata,
    input  logic                  cpu_aux_abort,
    output logic                  cpu_aux_rvalid,
    output logic [31:0]           cpu_aux_rdata,
    output logic [8:0]            cpu_aux_rtag,
    output logic [NUM_SLAVES-1:0] periph_sel,
    output logic [11:0]           periph_addr,
    output logic                  periph_write,
    output logic [3:0]            periph_wstrb,
    output logic [31:0]           periph_wdata,
    input  logic                  periph_ack,
    input  logic [31:0]           periph_rdata,
    output logic                  aux_overflow
);

    localparam int unsigned EW = 69;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    // Capture stage: reloads every cycle; the abort seen while it is occupied kills it.
    logic          c_valid_q;
    logic [EW-1:0] c_entry_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            c_valid_q <= 1'b0;
            c_entry_q <= '0;
        end else begin
            c_valid_q <= cpu_aux_request;
            c_entry_q <= {cpu_aux_addr, cpu_aux_write, cpu_aux_wstrb, cpu_aux_wdata};
        end
    end

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   fifo_cnt_q, fifo_cnt_d;
    logic          fifo_full, fifo_empty, push, push_ok, pop;
    logic          ovf_q;

    assign fifo_full  = (fifo_cnt_q == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt_q == '0);
    assign push       = c_valid_q && !cpu_aux_abort;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok    = push && (!fifo_full || pop);

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (push_ok && !pop) begin
            fifo_cnt_d = fifo_cnt_q + 1'b1;
        end else if (!push_ok && pop) begin
            fifo_cnt_d = fifo_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wptr_q] <= c_entry_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            fifo_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            fifo_cnt_q <= fifo_cnt_d;
            if (push && !push_ok) ovf_q <= 1'b1;
        end
    end

    logic [EW-1:0] head;
    logic [31:0]   head_addr, head_wdata;
    logic          head_write, head_mapped;
    logic [3:0]    head_wstrb;

    assign head        = mem_q[rptr_q];
    assign head_addr   = head[68:37];
    assign head_write  = head[36];
    assign head_wstrb  = head[35:32];
    assign head_wdata  = head[31:0];
    assign head_mapped = (head_addr[31:16] == AUX_BASE) &&
                         ({1'b0, head_addr[15:12]} < 5'(NUM_SLAVES));

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic [11:0]           paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [3:0]            pwstrb_q, pwstrb_d;
    logic [31:0]           pwdata_q, pwdata_d;
    logic [31:0]           data_q, data_d;
    logic                  cur_write_q, cur_write_d;
    logic [8:0]            cur_tag_q, cur_tag_d;
    logic                  rvalid_q, rvalid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [8:0]            rtag_q, rtag_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pop         = 1'b0;
        sel_d       = sel_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwstrb_d    = pwstrb_q;
        pwdata_d    = pwdata_q;
        data_d      = data_q;
        cur_write_d = cur_write_q;
        cur_tag_d   = cur_tag_q;
        rvalid_d    = 1'b0;
        rdata_d     = rdata_q;
        rtag_d      = rtag_q;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    cur_write_d = head_write;
                    cur_tag_d   = head_wdata[8:0];
                    data_d      = '0;
                    if (head_mapped) begin
                        sel_d    = NUM_SLAVES'(1) << head_addr[15:12];
                        paddr_d  = head_addr[11:0];
                        pwrite_d = head_write;
                        pwstrb_d = head_wstrb;
                        pwdata_d = head_wdata;
                        state_d  = StAccess;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StAccess: begin
                cnt_d = cnt_q + 1'b1;
                if (periph_ack) begin
                    data_d  = periph_rdata;
                    sel_d   = '0;
                    state_d = StResp;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    sel_d   = '0;
                    state_d = StResp;
                end
            end
            StResp: begin
                rvalid_d = !cur_write_q;
                if (!cur_write_q) begin
                    rdata_d = data_q;
                    rtag_d  = cur_tag_q;
                end
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sel_q       <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwstrb_q    <= '0;
            pwdata_q    <= '0;
            data_q      <= '0;
            cur_write_q <= 1'b0;
            cur_tag_q   <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rtag_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwstrb_q    <= pwstrb_d;
            pwdata_q    <= pwdata_d;
            data_q      <= data_d;
            cur_write_q <= cur_write_d;
            cur_tag_q   <= cur_tag_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rtag_q      <= rtag_d;
        end
    end

    assign cpu_aux_rvalid = rvalid_q;
    assign cpu_aux_rdata  = rdata_q;
    assign cpu_aux_rtag   = rtag_q;
    assign periph_sel     = sel_q;
    assign periph_addr    = paddr_q;
    assign periph_write   = pwrite_q;
    assign periph_wstrb   = pwstrb_q;
    assign periph_wdata   = pwdata_q;
    assign aux_overflow   = ovf_q;

endmodule

// File: tb/tb_aux_bus_bridge.sv
// Bench for aux_bus_bridge: a cycle-timeline model predicts every periph/response cycle
// from the latency rules, and a negedge compare process checks the DUT against it.
module tb_aux_bus_bridge;

    localparam int NS    = 8;
    localparam int DEPTH = 8;
    localparam int TMO   = 255;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          cpu_aux_request = 1'b0;
    logic [31:0]   cpu_aux_addr = '0;
    logic          cpu_aux_write = 1'b0;
    logic [3:0]    cpu_aux_wstrb = '0;
    logic [31:0]   cpu_aux_wdata = '0;
    logic          cpu_aux_abort = 1'b0;
    logic          cpu_aux_rvalid;
    logic [31:0]   cpu_aux_rdata;
    logic [8:0]    cpu_aux_rtag;
    logic [NS-1:0] periph_sel;
    logic [11:0]   periph_addr;
    logic          periph_write;
    logic [3:0]    periph_wstrb;
    logic [31:0]   periph_wdata;
    logic          periph_ack = 1'b0;
    logic [31:0]   periph_rdata = '0;
    logic          aux_overflow;

    aux_bus_bridge #(
        .NUM_SLAVES(NS),
        .FIFO_DEPTH(DEPTH),
        .AUX_BASE  (16'hE000),
        .TIMEOUT   (TMO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cpu_aux_request(cpu_aux_request),
        .cpu_aux_addr   (cpu_aux_addr),
        .cpu_aux_write  (cpu_aux_write),
        .cpu_aux_wstrb  (cpu_aux_wstrb),
        .cpu_aux_wdata  (cpu_aux_wdata),
        .cpu_aux_abort  (cpu_aux_abort),
        .cpu_aux_rvalid (cpu_aux_rvalid),
        .cpu_aux_rdata  (cpu_aux_rdata),
        .cpu_aux_rtag   (cpu_aux_rtag),
        .periph_sel     (periph_sel),
        .periph_addr    (periph_addr),
        .periph_write   (periph_write),
        .periph_wstrb   (periph_wstrb),
        .periph_wdata   (periph_wdata),
        .periph_ack     (periph_ack),
        .periph_rdata   (periph_rdata),
        .aux_overflow   (aux_overflow)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0]  sel;
        logic [11:0] addr;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } acc_t;
    typedef struct packed {
        logic [31:0] rdata;
        logic [8:0]  tag;
    } rsp_t;
    typedef struct {
        int p;
        int s;
    } item_t;

    acc_t        e_acc[int];
    rsp_t        e_rsp[int];
    logic [31:0] ack_at[int];
    item_t       items[$];
    int          free_cyc = 0;
    int          ovf_cyc = -1;

    int          n_vec = 0;
    int          n_err = 0;
    bit          abort_next = 1'b0;
    int          sel_cnt = 0;
    int          sel5_cnt = 0;
    logic [8:0]  tag_log[$];
    logic [31:0] data_log[$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    // Timeline model: request at N is pushed at P=N+1, popped at S, accessed S+1..S+d,
    // responds at S+d+2 (unmapped: S+2); the next pop may happen at that same cycle.
    task automatic model_push(input logic [31:0] addr, input logic wr, input logic [3:0] wstrb,
                              input logic [31:0] wdata, input int lat,
                              input logic [31:0] rdata);
        int          p;
        int          s;
        int          d;
        int          fin;
        int          occ;
        acc_t        a;
        rsp_t        r;
        logic [31:0] rd;
        p   = cyc + 1;
        occ = 0;
        foreach (items[i]) if (items[i].p < p && items[i].s > p) occ++;
        if (occ >= DEPTH) begin
            if (ovf_cyc < 0) ovf_cyc = p;
            return;
        end
        s  = (p + 1 > free_cyc) ? p + 1 : free_cyc;
        rd = '0;
        if (addr[31:16] == 16'hE000 && int'(addr[15:12]) < NS) begin
            d       = (lat >= 1 && lat <= TMO) ? lat : TMO;
            a.sel   = 8'(1) << addr[15:12];
            a.addr  = addr[11:0];
            a.wr    = wr;
            a.wstrb = wstrb;
            a.wdata = wdata;
            for (int k = 1; k <= d; k++) e_acc[s + k] = a;
            if (lat >= 1 && lat <= TMO) begin
                ack_at[s + lat] = rdata;
                rd = rdata;
            end
            fin = s + d + 1;
        end else begin
            fin = s + 1;
        end
        free_cyc = fin + 1;
        if (!wr) begin
            r.rdata = rd;
            r.tag   = wdata[8:0];
            e_rsp[fin + 1] = r;
        end
        items.push_back('{p, s});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cpu_aux_request = 1'b0;
        cpu_aux_abort   = abort_next;
        abort_next      = 1'b0;
    endtask

    task automatic issue(input logic [31:0] addr, input logic wr, input logic [3:0] wstrb,
                         input logic [31:0] wdata, input bit abort, input int lat,
                         input logic [31:0] rdata);
        cpu_aux_request = 1'b1;
        cpu_aux_addr    = addr;
        cpu_aux_write   = wr;
        cpu_aux_wstrb   = wstrb;
        cpu_aux_wdata   = wdata;
        abort_next      = abort;
        if (!abort) model_push(addr, wr, wstrb, wdata, lat, rdata);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_resp"}, 64'({cpu_aux_rvalid, cpu_aux_rdata, cpu_aux_rtag}), 64'(0));
        check({tag, "_periph"}, 64'({periph_sel, periph_addr, periph_write, periph_wstrb}),
              64'(0));
        check({tag, "_wdata"}, 64'(periph_wdata), 64'(0));
        check({tag, "_ovf"}, 64'(aux_overflow), 64'(0));
    endtask

    // Bench slave: acks exactly on the cycles the model scheduled.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (ack_at.exists(cyc)) begin
                periph_ack   = 1'b1;
                periph_rdata = ack_at[cyc];
            end else begin
                periph_ack   = 1'b0;
                periph_rdata = 32'hDEADBEEF;
            end
        end
    end

    always @(negedge clock) begin
        acc_t ea;
        rsp_t er;
        bit   erv;
        ea = '0;
        if (e_acc.exists(cyc)) ea = e_acc[cyc];
        check("periph_sel", 64'(periph_sel), 64'(ea.sel));
        if (ea.sel != 0) begin
            check("periph_addr", 64'(periph_addr), 64'(ea.addr));
            check("periph_write", 64'(periph_write), 64'(ea.wr));
            check("periph_wstrb", 64'(periph_wstrb), 64'(ea.wstrb));
            check("periph_wdata", 64'(periph_wdata), 64'(ea.wdata));
        end
        erv = e_rsp.exists(cyc);
        check("rvalid", 64'(cpu_aux_rvalid), 64'(erv));
        if (erv && cpu_aux_rvalid) begin
            er = e_rsp[cyc];
            check("rdata", 64'(cpu_aux_rdata), 64'(er.rdata));
            check("rtag", 64'(cpu_aux_rtag), 64'(er.tag));
        end
        check("aux_overflow", 64'(aux_overflow), 64'(ovf_cyc >= 0 && cyc > ovf_cyc));
        if (periph_sel != 0) sel_cnt++;
        if (periph_sel == 8'h20) sel5_cnt++;
        if (cpu_aux_rvalid) begin
            tag_log.push_back(cpu_aux_rtag);
            data_log.push_back(cpu_aux_rdata);
        end
    end

    initial begin
        int n0;
        int s0;
        int r0;
        int c0;

        tick();
        check_all_zero("reset");
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Mapped read, zero-wait slave
        issue(32'hE000_2004, 1'b0, 4'h0, 32'h0000_01A5, 1'b0, 1, 32'h1234_5678);
        n0 = cyc;
        repeat (3) tick();
        check("t1_sel_n3", 64'(cyc - n0), 64'(3));
        check("t1_sel", 64'(periph_sel), 64'(8'h04));
        check("t1_addr", 64'(periph_addr), 64'(12'h004));
        tick();
        check("t1_rvalid_n4", 64'(cpu_aux_rvalid), 64'(0));
        tick();
        check("t1_rvalid_n5", 64'(cpu_aux_rvalid), 64'(1));
        check("t1_rdata", 64'(cpu_aux_rdata), 64'(32'h1234_5678));
        check("t1_rtag", 64'(cpu_aux_rtag), 64'(9'h1A5));
        repeat (4) tick();

        // Aborted write never reaches the slave bus
        s0 = sel_cnt;
        r0 = tag_log.size();
        issue(32'hE000_1010, 1'b1, 4'h3, 32'hCAFE_BABE, 1'b1, 1, 32'h0);
        repeat (8) tick();
        check("t2_no_sel", 64'(sel_cnt - s0), 64'(0));
        check("t2_no_rvalid", 64'(tag_log.size() - r0), 64'(0));

        // Three back-to-back reads, middle one aborted
        r0 = tag_log.size();
        issue(32'hE000_3000, 1'b0, 4'h0, 32'h1, 1'b0, 1, 32'h1111_1111);
        tick();
        issue(32'hE000_3004, 1'b0, 4'h0, 32'h2, 1'b1, 1, 32'h2222_2222);
        tick();
        issue(32'hE000_3008, 1'b0, 4'h0, 32'h3, 1'b0, 1, 32'h3333_3333);
        repeat (12) tick();
        check("t3_count", 64'(tag_log.size() - r0), 64'(2));
        if (tag_log.size() >= r0 + 2) begin
            check("t3_tag_first", 64'(tag_log[r0]), 64'(1));
            check("t3_tag_second", 64'(tag_log[r0+1]), 64'(3));
            check("t3_data_second", 64'(data_log[r0+1]), 64'(32'h3333_3333));
        end

        // Unmapped read answers with zero, no peripheral cycle
        s0 = sel_cnt;
        issue(32'h1000_0000, 1'b0, 4'h0, 32'h7, 1'b0, 1, 32'h0);
        n0 = cyc;
        repeat (4) tick();
        check("t4_lat", 64'(cyc - n0), 64'(4));
        check("t4_rvalid", 64'(cpu_aux_rvalid), 64'(1));
        check("t4_rdata", 64'(cpu_aux_rdata), 64'(0));
        check("t4_rtag", 64'(cpu_aux_rtag), 64'(7));
        repeat (3) tick();
        check("t4_no_sel", 64'(sel_cnt - s0), 64'(0));

        // Timeout on slave 5, then a queued read to slave 1 proceeds
        c0 = sel5_cnt;
        r0 = tag_log.size();
        issue(32'hE000_5000, 1'b0, 4'h0, 32'h55, 1'b0, 0, 32'h0);
        tick();
        issue(32'hE000_1008, 1'b0, 4'h0, 32'h66, 1'b0, 2, 32'hA5A5_F00D);
        repeat (270) tick();
        check("t5_sel_cycles", 64'(sel5_cnt - c0), 64'(255));
        check("t5_count", 64'(tag_log.size() - r0), 64'(2));
        if (tag_log.size() >= r0 + 2) begin
            check("t5_tag_to", 64'(tag_log[r0]), 64'(9'h055));
            check("t5_data_to", 64'(data_log[r0]), 64'(0));
            check("t5_tag_next", 64'(tag_log[r0+1]), 64'(9'h066));
            check("t5_data_next", 64'(data_log[r0+1]), 64'(32'hA5A5_F00D));
        end

        // Ten writes against a stalled slave overflow the FIFO; reset mid-access
        r0 = tag_log.size();
        for (int i = 0; i < 10; i++) begin
            issue(32'hE000_0000 + 32'(i * 4), 1'b1, 4'hF, 32'h1000 + 32'(i), 1'b0, 0, 32'h0);
            tick();
        end
        repeat (5) tick();
        check("t6_overflow", 64'(aux_overflow), 64'(1));
        check("t6_sel_slave0", 64'(periph_sel), 64'(8'h01));
        #2;
        reset = 1'b0;
        e_acc.delete();
        e_rsp.delete();
        ack_at.delete();
        items.delete();
        free_cyc = 0;
        ovf_cyc  = -1;
        #1;
        check_all_zero("t6_async");
        tick();
        tick();
        reset = 1'b1;
        repeat (5) tick();
        issue(32'hE000_7FFC, 1'b0, 4'h0, 32'h1FF, 1'b0, 3, 32'h0BAD_F00D);
        repeat (10) tick();
        check("t6_after_reset", 64'(tag_log.size() - r0), 64'(1));
        if (tag_log.size() >= r0 + 1) begin
            check("t6_tag", 64'(tag_log[r0]), 64'(9'h1FF));
            check("t6_data", 64'(data_log[r0]), 64'(32'h0BAD_F00D));
        end
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
